lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: W, 32, datapath width; only W=32 is supported.
REQ-002 Ports (name  direction  width  meaning):
  clk  in  1  sole clock, all state updates on rising edge
  rst  in  1  synchronous, active-high reset
  in_valid  in  1  execute stage presents a memory op
  in_ready  out  1  LSU can accept an op this cycle
  is_load  in  1  op is a load
  is_store  in  1  op is a store
  funct3  in  3  RV32I width/sign code
  addr  in  W  effective address, taken from ALU y
  wdata  in  W  store data (rs2)
  rd  in  5  load destination register
  mem_req  out  1  data-memory request
  mem_we  out  1  1 = write
  mem_addr  out  W  word-aligned address: {addr[W-1:2],2'b00}
  mem_be  out  4  byte enables
  mem_wdata  out  W  lane-aligned store data
  mem_gnt  in  1  memory accepted request
  mem_rvalid  in  1  read data valid
  mem_rdata  in  W  read data
  out_valid  out  1  one-cycle completion pulse
  out_rdata  out  W  extended load result; 0 for stores and errors
  out_rd  out  5  rd of the completed op
  out_err  out  1  misaligned or illegal funct3

Function
REQ-003 FSM states: IDLE, REQ, WAIT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-004 Accept when in_valid & in_ready & (is_load ^ is_store); register addr, wdata, funct3, rd, and op type.
REQ-005 in_valid with is_load==is_store SHALL be ignored: no state change, no output.
REQ-006 Legal funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW; any other value is illegal.
REQ-007 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-008 Illegal or misaligned op: IDLE->DONE, mem_req never asserted, out_err=1, out_rdata=0.
REQ-009 Legal op: IDLE->REQ; in REQ, mem_req=1 with mem_we/addr/be/wdata held stable until the cycle mem_gnt=1.
REQ-010 REQ + mem_gnt: store -> DONE; load -> WAIT.
REQ-011 WAIT + mem_rvalid: capture extended data -> DONE; memory SHALL NOT assert rvalid in the gnt cycle.
REQ-012 DONE: out_valid=1 for exactly one cycle with out_rd and out_err; then -> IDLE.
REQ-013 Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011 (addr[1]=0) or 4'b1100; SW 4'b1111.
REQ-014 Store data replicated across lanes: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-015 Load extraction: select byte/half lane by addr[1:0]/addr[1]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes mem_rdata through.
REQ-016 out_rdata, out_rd, out_err are valid only when out_valid=1; they SHALL be 0 outside DONE.
REQ-017 mem_rvalid outside WAIT SHALL be ignored.
REQ-018 Minimum latency (accept edge to out_valid): store 2 cycles and load 3 cycles with same-cycle gnt; error 1 cycle.

Reset
REQ-019 rst=1 at a clock edge forces IDLE from any state, including mid-REQ or mid-WAIT.
REQ-020 While rst=1 and after it: mem_req=0, out_valid=0, out_err=0, out_rdata=0, out_rd=0, in_ready=1 once rst=0.
REQ-021 An op interrupted by reset SHALL NOT produce out_valid; a late mem_rvalid after reset is ignored.

Verification
REQ-022 SW addr=0x100, wdata=0xDEADBEEF, gnt same cycle -> mem_req one cycle, mem_addr=0x100, be=1111, mem_we=1; out_valid 2 cycles after accept, out_err=0.
REQ-023 LB addr=0x203, rdata=0x80FF_0000, rd=5 -> out_rdata=0xFFFFFF80, out_rd=5; LBU at the same address -> 0x00000080.
REQ-024 SH addr=0x12, wdata=0x0000ABCD -> be=1100, mem_wdata=0xABCDABCD; LH addr=0x11 -> no mem_req, out_valid with out_err=1, out_rdata=0.
REQ-025 LW with mem_gnt held low 3 cycles -> mem_req held and mem_addr stable for 4 cycles, in_ready=0 throughout; out_rdata equals mem_rdata.
REQ-026 rst asserted in WAIT, then mem_rvalid=1 the next cycle -> no out_valid; in_ready=1 after reset.
REQ-027 in_valid with is_load=is_store=1, and a load with funct3=011 -> first ignored (no out_valid); second gives out_err=1 with no mem_req.

Source files
------------

// File: rtl/lsu.sv
// RV32I load/store unit: one outstanding data-memory access with request/grant
// and read-valid handshakes, lane steering for stores and extension for loads.
module lsu #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         is_load,
  input  logic         is_store,
  input  logic [2:0]   funct3,
  input  logic [W-1:0] addr,
  input  logic [W-1:0] wdata,
  input  logic [4:0]   rd,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [3:0]   mem_be,
  output logic [W-1:0] mem_wdata,
  input  logic         mem_gnt,
  input  logic         mem_rvalid,
  input  logic [W-1:0] mem_rdata,
  output logic         out_valid,
  output logic [W-1:0] out_rdata,
  output logic [4:0]   out_rd,
  output logic         out_err
);

  // state | meaning
  // IDLE  | waiting for an op, in_ready=1
  // REQ   | mem_req held until mem_gnt
  // WAIT  | load granted, waiting for mem_rvalid
  // DONE  | one-cycle completion pulse on out_valid
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic        op_load;
  logic [2:0]  op_f3;
  logic [1:0]  op_off;
  logic [4:0]  op_rd;

  logic        accept;
  logic        legal;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [W-1:0] wdata_next;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [W-1:0] ld_data;

  assign accept     = in_valid & in_ready & (is_load ^ is_store);
  assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = is_load;
      default:                legal = 1'b0;
    endcase
  end

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_next    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (op_off)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      2'd3: ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = op_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data = '0;
    case (op_f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      3'b010:  ld_data = mem_rdata;
      default: ld_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
      out_valid <= 1'b0;
      out_rdata <= '0;
      out_rd    <= 5'd0;
      out_err   <= 1'b0;
      op_load   <= 1'b0;
      op_f3     <= 3'd0;
      op_off    <= 2'd0;
      op_rd     <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_load  <= is_load;
            op_f3    <= funct3;
            op_off   <= addr[1:0];
            op_rd    <= rd;
            in_ready <= 1'b0;
            if (!legal || misaligned) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_rdata <= '0;
              out_rd    <= rd;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[W-1:2], 2'b00};
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (op_load) begin
              state <= WAIT;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_err   <= 1'b0;
              out_rdata <= '0;
              out_rd    <= op_rd;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            out_rdata <= ld_data;
            out_rd    <= op_rd;
          end
        end
        DONE: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_err   <= 1'b0;
          out_rdata <= '0;
          out_rd    <= 5'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized ops checked
// against an arithmetic reference model with a responsive memory stub.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [4:0]  rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        out_valid, out_err;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;

  int errors = 0;
  int checks = 0;

  lsu #(.W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_rdata(out_rdata), .out_rd(out_rd),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off,
                                             input logic [31:0] data);
    logic [31:0] b, h;
    b = (data >> (8 * off)) & 32'hFF;
    h = (data >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      3'd2:    return data;
      default: return 32'd0;
    endcase
  endfunction

  task automatic quiet_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_outs"}, out_rdata | {26'd0, out_err, out_rd}, 32'd0);
    check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
  endtask

  // Caller sits at a negedge; returns at the negedge after the completion pulse.
  task automatic do_op(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] r, input int gd,
                       input int rvd, input logic [31:0] rdat, output logic [31:0] got);
    bit legal, exp_err, gnt_set, in_wait, done;
    int sz, off, exp_lat, cyc, req_n, wait_n;
    logic [31:0] exp_be, exp_wd, exp_rdata;
    got   = 32'd0;
    off   = int'(a % 4);
    legal = ld ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
    sz    = 1 << (f3 % 4);
    exp_err = !legal || ((a % sz) != 0);
    case (f3 % 4)
      0:       begin exp_be = 32'd1 << off; exp_wd = (wd & 32'hFF) * 32'h0101_0101; end
      1:       begin exp_be = 32'd3 << off; exp_wd = (wd & 32'hFFFF) * 32'h0001_0001; end
      default: begin exp_be = 32'hF;        exp_wd = wd; end
    endcase
    exp_rdata = (exp_err || !ld) ? 32'd0 : model_load(f3, off, rdat);
    exp_lat   = exp_err ? 1 : (ld ? gd + rvd + 3 : gd + 2);

    check("ready_before", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; is_load = ld; is_store = !ld;
    funct3 = f3; addr = a; wdata = wd; rd = r;
    @(negedge clk);
    in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    addr = $urandom; wdata = $urandom; rd = 5'($urandom); funct3 = 3'($urandom);

    cyc = 0; req_n = 0; wait_n = 0; gnt_set = 0; in_wait = 0; done = 0;
    while (!done && cyc < 60) begin
      cyc++;
      if (out_valid) begin
        done = 1;
        got  = out_rdata;
        check("latency", cyc, exp_lat);
        check("out_err", {31'd0, out_err}, {31'd0, exp_err});
        check("out_rdata", out_rdata, exp_rdata);
        check("out_rd", {27'd0, out_rd}, {27'd0, r});
      end else begin
        check("busy_outs", out_rdata | {26'd0, out_err, out_rd}, 32'd0);
        check("busy_ready", {31'd0, in_ready}, 32'd0);
      end
      if (gnt_set) begin
        mem_gnt = 1'b0; gnt_set = 0;
        if (ld) begin in_wait = 1; wait_n = 0; end
      end
      if (mem_req) begin
        check("req_on_err", {31'd0, exp_err}, 32'd0);
        check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
        check("mem_we", {31'd0, mem_we}, {31'd0, !ld});
        if (!ld) begin
          check("mem_be", {28'd0, mem_be}, exp_be);
          check("mem_wdata", mem_wdata, exp_wd);
        end
        if (req_n == gd) begin mem_gnt = 1'b1; gnt_set = 1; end
        req_n++;
      end
      if (in_wait) begin
        if (wait_n == rvd) begin
          mem_rvalid = 1'b1; mem_rdata = rdat; in_wait = 0;
        end else begin
          mem_rvalid = 1'b0; mem_rdata = $urandom;
        end
        wait_n++;
      end else begin
        mem_rvalid = 1'b0;
      end
      if (!done) @(negedge clk);
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    check("req_cycles", req_n, exp_err ? 0 : gd + 1);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    check("pulse_end", {31'd0, out_valid}, 32'd0);
    check("ready_after", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic bad_handshake(input logic both);
    in_valid = 1'b1; is_load = both; is_store = both;
    funct3 = 3'd2; addr = 32'h40; rd = 5'd3;
    @(negedge clk);
    in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    for (int i = 0; i < 3; i++) begin
      quiet_outputs("ignored");
      check("ignored_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] got;
    rst = 1'b1; in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'd0; addr = '0; wdata = '0; rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    quiet_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'd0, in_ready}, 32'd1);

    do_op(1'b0, 3'd2, 32'h100, 32'hDEAD_BEEF, 5'd1, 0, 0, 32'd0, got);
    check("sw_rdata", got, 32'd0);
    do_op(1'b1, 3'd0, 32'h203, 32'd0, 5'd5, 0, 1, 32'h80FF_0000, got);
    check("lb_value", got, 32'hFFFF_FF80);
    do_op(1'b1, 3'd4, 32'h203, 32'd0, 5'd5, 1, 0, 32'h80FF_0000, got);
    check("lbu_value", got, 32'h0000_0080);
    do_op(1'b0, 3'd1, 32'h12, 32'h0000_ABCD, 5'd2, 0, 0, 32'd0, got);
    do_op(1'b1, 3'd1, 32'h11, 32'd0, 5'd7, 0, 0, 32'h1234_5678, got);
    do_op(1'b1, 3'd2, 32'h80, 32'd0, 5'd9, 3, 2, 32'hCAFE_F00D, got);
    check("lw_value", got, 32'hCAFE_F00D);
    bad_handshake(1'b1);
    bad_handshake(1'b0);
    do_op(1'b1, 3'd3, 32'h40, 32'd0, 5'd4, 0, 0, 32'd0, got);

    // Reset while a load waits for read data; the late rvalid must be dropped.
    in_valid = 1'b1; is_load = 1'b1; funct3 = 3'd2; addr = 32'h44; rd = 5'd6;
    @(negedge clk);
    in_valid = 1'b0; is_load = 1'b0;
    check("rw_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rw_wait_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    quiet_outputs("rst_wait");
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      quiet_outputs("post_rst");
      check("post_rst_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
    end

    // Reset while a store is still requesting.
    in_valid = 1'b1; is_store = 1'b1; funct3 = 3'd2; addr = 32'h48;
    @(negedge clk);
    in_valid = 1'b0; is_store = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    quiet_outputs("rst_req");
    check("rst_req_ready", {31'd0, in_ready}, 32'd1);

    for (int n = 0; n < 150; n++) begin
      int gap;
      gap = $urandom_range(2, 0);
      for (int g = 0; g < gap; g++) begin
        mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        @(negedge clk);
        mem_rvalid = 1'b0;
        quiet_outputs("gap");
      end
      if ($urandom_range(9, 0) == 0) bad_handshake(1'($urandom));
      else do_op(1'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom),
                 $urandom_range(3, 0), $urandom_range(3, 0), $urandom, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
